// File: rtl/core_dispatch_scoreboard_pkg.sv
// Shared core micro-architecture types: register numbers, 16-bit register
// masks and the decoded-instruction record presented to dispatch.
package core_dispatch_scoreboard_pkg;

  typedef logic [15:0] hword;
  typedef logic [3:0]  reg_num;

  // Execution-unit class of a decoded instruction.
  typedef enum logic [1:0] {
    EU_ALU    = 2'd0,
    EU_MUL    = 2'd1,
    EU_BRANCH = 2'd2,
    EU_LDST   = 2'd3
  } eu_class_e;

  typedef struct packed {
    logic      execute;
    eu_class_e eu_class;
  } insn_ctrl;

  typedef struct packed {
    reg_num rd;
    reg_num ra;
    reg_num rb;
    logic   writeback;
    logic   uses_ra;
    logic   uses_rb;
  } insn_data;

  typedef struct packed {
    insn_ctrl ctrl;
    insn_data data;
  } insn_decode;

  // One-hot register mask for register number r.
  function automatic hword reg_bit(input reg_num r);
    return hword'(1) << r;
  endfunction

endpackage

// File: rtl/core_dispatch_mul_track.sv
// Multiplier latency tracker: a MUL_LATENCY-deep shift pipe of (valid, rd).
// An entry pushed at edge N is presented on exit_valid/exit_rd during the
// cycle before edge N+MUL_LATENCY, so the owner clears its bit on that edge.
// live_mask lists destinations still in flight behind the exiting entry, so
// an older mul never clears a bit a younger mul to the same rd still owns.
// MUL_LATENCY legal range: 1..8.
module core_dispatch_mul_track
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  reg_num push_rd,
  output logic   exit_valid,
  output reg_num exit_rd,
  output hword   live_mask
);

  logic [MUL_LATENCY-1:0] valid_q;
  reg_num                 rd_q [MUL_LATENCY];

  // Advance every entry one stage per cycle; a new mul enters stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the rd payload is reset along with valid; the pipe is a handful of flops, so there is no RAM to keep reset-free and a flush leaves no stale rd behind.
      valid_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) rd_q[i] <= '0;
    end else begin
      valid_q[0] <= push;
      rd_q[0]    <= push_rd;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
    end
  end

  // Destinations still in flight after this edge (all stages but the last).
  always_comb begin
    live_mask = '0;
    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
      if (valid_q[i]) live_mask = live_mask | reg_bit(rd_q[i]);
    end
  end

  assign exit_valid = valid_q[MUL_LATENCY-1];
  assign exit_rd    = rd_q[MUL_LATENCY-1];

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// Dispatch scoreboard: per-EU masks of registers with a write in flight,
// plus zero-latency one-hot read-operand masks for the current pair.
// Optional feature macro CORE_MUL_EN: when defined, mul-class instructions
// are tracked in mask_mul and retired by a fixed-latency pipe; when undefined,
// mask_mul is tied to 0 and mul instructions are tracked as ALU per slot.
// The dispatcher issues at most one mul per cycle (single multiplier).
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  insn_decode cur_a,
  input  insn_decode cur_b,
  input  logic       dispatch_a,
  input  logic       dispatch_b,
  input  logic       wb_alu_a,
  input  logic       wb_alu_b,
  input  logic       wb_branch,
  input  logic       wb_ldst,
  input  reg_num     wb_alu_a_rd,
  input  reg_num     wb_alu_b_rd,
  input  reg_num     wb_branch_rd,
  input  reg_num     wb_ldst_rd,
  output hword       mask_alu_a,
  output hword       mask_alu_b,
  output hword       mask_branch,
  output hword       mask_mul,
  output hword       mask_ldst,
  output hword       mask_a_ra,
  output hword       mask_a_rb,
  output hword       mask_b_ra,
  output hword       mask_b_rb,
  output logic       busy
);

  logic set_a_en, set_b_en;
  hword set_alu_a, set_alu_b, set_branch, set_ldst;
  hword clr_alu_a, clr_alu_b, clr_branch, clr_ldst;
`ifdef CORE_MUL_EN
  hword   set_mul, clr_mul, mul_live;
  logic   mul_push, mul_exit;
  reg_num mul_push_rd, mul_exit_rd;
`endif

  // Slot B only issues behind slot A in the same cycle.
  assign set_a_en = dispatch_a && cur_a.ctrl.execute && cur_a.data.writeback;
  assign set_b_en = dispatch_a && dispatch_b && cur_b.ctrl.execute && cur_b.data.writeback;

  // Route each slot's destination to the mask of the EU that will write it.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can hold a stale value and infer a latch.
    set_alu_a  = '0;
    set_alu_b  = '0;
    set_branch = '0;
    set_ldst   = '0;
`ifdef CORE_MUL_EN
    set_mul     = '0;
    mul_push    = 1'b0;
    mul_push_rd = '0;
`endif
    if (set_a_en) begin
      unique case (cur_a.ctrl.eu_class)
        EU_BRANCH: set_branch = set_branch | reg_bit(cur_a.data.rd);
        EU_LDST:   set_ldst   = set_ldst   | reg_bit(cur_a.data.rd);
`ifdef CORE_MUL_EN
        EU_MUL: begin
          set_mul     = set_mul | reg_bit(cur_a.data.rd);
          mul_push    = 1'b1;
          mul_push_rd = cur_a.data.rd;
        end
`endif
        default:   set_alu_a  = set_alu_a  | reg_bit(cur_a.data.rd);
      endcase
    end
    if (set_b_en) begin
      unique case (cur_b.ctrl.eu_class)
        EU_BRANCH: set_branch = set_branch | reg_bit(cur_b.data.rd);
        EU_LDST:   set_ldst   = set_ldst   | reg_bit(cur_b.data.rd);
`ifdef CORE_MUL_EN
        EU_MUL: begin
          set_mul = set_mul | reg_bit(cur_b.data.rd);
          if (!mul_push) begin
            mul_push    = 1'b1;
            mul_push_rd = cur_b.data.rd;
          end
        end
`endif
        default:   set_alu_b  = set_alu_b  | reg_bit(cur_b.data.rd);
      endcase
    end
  end

  assign clr_alu_a  = wb_alu_a  ? reg_bit(wb_alu_a_rd)  : '0;
  assign clr_alu_b  = wb_alu_b  ? reg_bit(wb_alu_b_rd)  : '0;
  assign clr_branch = wb_branch ? reg_bit(wb_branch_rd) : '0;
  assign clr_ldst   = wb_ldst   ? reg_bit(wb_ldst_rd)   : '0;

  // EU masks: drop retiring bits, then OR in new sets so a set wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_alu_a  <= '0;
      mask_alu_b  <= '0;
      mask_branch <= '0;
      mask_ldst   <= '0;
    end else begin
      // NOTE: non-blocking updates, so every mask samples the pre-edge state and ordering inside the block is irrelevant.
      mask_alu_a  <= (mask_alu_a  & ~clr_alu_a)  | set_alu_a;
      mask_alu_b  <= (mask_alu_b  & ~clr_alu_b)  | set_alu_b;
      mask_branch <= (mask_branch & ~clr_branch) | set_branch;
      mask_ldst   <= (mask_ldst   & ~clr_ldst)   | set_ldst;
    end
  end

`ifdef CORE_MUL_EN
  core_dispatch_mul_track #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_track (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (mul_push),
    .push_rd    (mul_push_rd),
    .exit_valid (mul_exit),
    .exit_rd    (mul_exit_rd),
    .live_mask  (mul_live)
  );

  // A retiring mul clears its bit only if no younger mul to the same rd is in flight.
  assign clr_mul = (mul_exit && !mul_live[mul_exit_rd]) ? reg_bit(mul_exit_rd) : '0;

  // Mul mask: same set-over-clear update as the other EUs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_mul <= '0;
    else        mask_mul <= (mask_mul & ~clr_mul) | set_mul;
  end
`else
  assign mask_mul = '0;
`endif

  // Read-operand masks are combinational views of the current pair.
  assign mask_a_ra = (cur_a.ctrl.execute && cur_a.data.uses_ra) ? reg_bit(cur_a.data.ra) : '0;
  assign mask_a_rb = (cur_a.ctrl.execute && cur_a.data.uses_rb) ? reg_bit(cur_a.data.rb) : '0;
  assign mask_b_ra = (cur_b.ctrl.execute && cur_b.data.uses_ra) ? reg_bit(cur_b.data.ra) : '0;
  assign mask_b_rb = (cur_b.ctrl.execute && cur_b.data.uses_rb) ? reg_bit(cur_b.data.rb) : '0;

  assign busy = |{mask_alu_a, mask_alu_b, mask_branch, mask_mul, mask_ldst};

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// Self-checking bench for core_dispatch_scoreboard (MUL_LATENCY = 3).
// Expected mask values come from a table and hand-written sequences; they are
// queued when stimulus is driven and compared after the following clock edge.
// Mul expectations follow CORE_MUL_EN: enabled -> mask_mul, disabled -> ALU.
module tb_core_dispatch_scoreboard;
  import core_dispatch_scoreboard_pkg::*;

  localparam int MUL_LATENCY = 3;
`ifdef CORE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  insn_decode cur_a, cur_b;
  logic       dispatch_a, dispatch_b;
  logic       wb_alu_a, wb_alu_b, wb_branch, wb_ldst;
  reg_num     wb_alu_a_rd, wb_alu_b_rd, wb_branch_rd, wb_ldst_rd;
  hword       mask_alu_a, mask_alu_b, mask_branch, mask_mul, mask_ldst;
  hword       mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb;
  logic       busy;

  core_dispatch_scoreboard #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cur_a        (cur_a),
    .cur_b        (cur_b),
    .dispatch_a   (dispatch_a),
    .dispatch_b   (dispatch_b),
    .wb_alu_a     (wb_alu_a),
    .wb_alu_b     (wb_alu_b),
    .wb_branch    (wb_branch),
    .wb_ldst      (wb_ldst),
    .wb_alu_a_rd  (wb_alu_a_rd),
    .wb_alu_b_rd  (wb_alu_b_rd),
    .wb_branch_rd (wb_branch_rd),
    .wb_ldst_rd   (wb_ldst_rd),
    .mask_alu_a   (mask_alu_a),
    .mask_alu_b   (mask_alu_b),
    .mask_branch  (mask_branch),
    .mask_mul     (mask_mul),
    .mask_ldst    (mask_ldst),
    .mask_a_ra    (mask_a_ra),
    .mask_a_rb    (mask_a_rb),
    .mask_b_ra    (mask_b_ra),
    .mask_b_rb    (mask_b_rb),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    hword  alu_a, alu_b, branch, mul, ldst;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    string     name;
    logic      da;  eu_class_e a_cls; reg_num a_rd;
    logic      db;  eu_class_e b_cls; reg_num b_rd;
    logic      wa;  reg_num wa_rd;
    logic      wb;  reg_num wb_rd;
    logic      wbr; reg_num wbr_rd;
    logic      wl;  reg_num wl_rd;
    hword      ea, eb, ebr, eld;
  } vec_t;

  typedef struct {
    reg_num ra, rb;
    logic   ura, urb, exe;
    hword   e_ra, e_rb;
  } rd_vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic insn_decode mk_insn(input eu_class_e cls, input reg_num rd,
                                         input reg_num ra, input reg_num rb,
                                         input logic ura, input logic urb,
                                         input logic exe, input logic wbk);
    insn_decode d;
    d.ctrl.execute   = exe;
    d.ctrl.eu_class  = cls;
    d.data.rd        = rd;
    d.data.ra        = ra;
    d.data.rb        = rb;
    d.data.writeback = wbk;
    d.data.uses_ra   = ura;
    d.data.uses_rb   = urb;
    return d;
  endfunction

  function automatic insn_decode op(input eu_class_e cls, input reg_num rd);
    return mk_insn(cls, rd, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction

  task automatic idle_inputs();
    cur_a = '0; cur_b = '0;
    dispatch_a = 1'b0; dispatch_b = 1'b0;
    wb_alu_a = 1'b0; wb_alu_b = 1'b0; wb_branch = 1'b0; wb_ldst = 1'b0;
    wb_alu_a_rd = '0; wb_alu_b_rd = '0; wb_branch_rd = '0; wb_ldst_rd = '0;
  endtask

  // Queue the expected masks for the current stimulus, clock once, then compare.
  task automatic step(input string name, input hword ea, input hword eb, input hword ebr,
                      input hword emu, input hword eld);
    exp_t e;
    exp_t g;
    e.name = name; e.alu_a = ea; e.alu_b = eb; e.branch = ebr; e.mul = emu; e.ldst = eld;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", name);
    end else begin
      g = sb_q.pop_front();
      check({g.name, ".alu_a"},  mask_alu_a,  g.alu_a);
      check({g.name, ".alu_b"},  mask_alu_b,  g.alu_b);
      check({g.name, ".branch"}, mask_branch, g.branch);
      check({g.name, ".mul"},    mask_mul,    g.mul);
      check({g.name, ".ldst"},   mask_ldst,   g.ldst);
      check({g.name, ".busy"},   {15'd0, busy},
            {15'd0, |{g.alu_a, g.alu_b, g.branch, g.mul, g.ldst}});
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".alu_a"},  mask_alu_a,  16'h0);
    check({name, ".alu_b"},  mask_alu_b,  16'h0);
    check({name, ".branch"}, mask_branch, 16'h0);
    check({name, ".mul"},    mask_mul,    16'h0);
    check({name, ".ldst"},   mask_ldst,   16'h0);
    check({name, ".busy"},   {15'd0, busy}, 16'h0);
  endtask

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t    vecs [9];
  rd_vec_t rvecs [4];

  initial begin
    vecs[0] = '{"add_r3",          1'b1, EU_ALU, 4'd3,    1'b0, EU_ALU, 4'd0,
                1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0008, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{"add_r3_hold",     1'b0, EU_ALU, 4'd0,    1'b0, EU_ALU, 4'd0,
                1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0008, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{"wb_alu_a_r3",     1'b0, EU_ALU, 4'd0,    1'b0, EU_ALU, 4'd0,
                1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{"branch_ldst",     1'b1, EU_BRANCH, 4'd1, 1'b1, EU_LDST, 4'd8,
                1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0000, 16'h0000, 16'h0002, 16'h0100};
    vecs[4] = '{"alu_pair_r7",     1'b1, EU_ALU, 4'd7,    1'b1, EU_ALU, 4'd7,
                1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0080, 16'h0080, 16'h0002, 16'h0100};
    vecs[5] = '{"set_beats_clr_r7", 1'b1, EU_BRANCH, 4'd1, 1'b1, EU_ALU, 4'd7,
                1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0080, 16'h0080, 16'h0002, 16'h0100};
    vecs[6] = '{"clr_unset_bit",   1'b0, EU_ALU, 4'd0,    1'b0, EU_ALU, 4'd0,
                1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0,
                16'h0080, 16'h0080, 16'h0000, 16'h0100};
    vecs[7] = '{"b_without_a",     1'b0, EU_ALU, 4'd0,    1'b1, EU_LDST, 4'd2,
                1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                16'h0080, 16'h0080, 16'h0000, 16'h0100};
    vecs[8] = '{"drain",           1'b0, EU_ALU, 4'd0,    1'b0, EU_ALU, 4'd0,
                1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 4'd8,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};

    rvecs[0] = '{4'd4, 4'd9,  1'b1, 1'b1, 1'b1, 16'h0010, 16'h0200};
    rvecs[1] = '{4'd0, 4'd15, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h8000};
    rvecs[2] = '{4'd4, 4'd9,  1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200};
    rvecs[3] = '{4'd4, 4'd9,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};

    // Reset state before any clock edge.
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    #11;
    rst_n = 1'b1;

    // Combinational read-operand masks; slot B gets ra/rb swapped.
    foreach (rvecs[i]) begin
      cur_a = mk_insn(EU_ALU, 4'd1, rvecs[i].ra, rvecs[i].rb,
                      rvecs[i].ura, rvecs[i].urb, rvecs[i].exe, 1'b1);
      cur_b = mk_insn(EU_ALU, 4'd1, rvecs[i].rb, rvecs[i].ra,
                      rvecs[i].urb, rvecs[i].ura, rvecs[i].exe, 1'b1);
      #1;
      check($sformatf("rd_mask%0d.a_ra", i), mask_a_ra, rvecs[i].e_ra);
      check($sformatf("rd_mask%0d.a_rb", i), mask_a_rb, rvecs[i].e_rb);
      check($sformatf("rd_mask%0d.b_ra", i), mask_b_ra, rvecs[i].e_rb);
      check($sformatf("rd_mask%0d.b_rb", i), mask_b_rb, rvecs[i].e_ra);
    end
    idle_inputs();
    @(posedge clk);
    #1;

    // Table-driven single-cycle vectors.
    foreach (vecs[i]) begin
      cur_a        = op(vecs[i].a_cls, vecs[i].a_rd);
      cur_b        = op(vecs[i].b_cls, vecs[i].b_rd);
      dispatch_a   = vecs[i].da;
      dispatch_b   = vecs[i].db;
      wb_alu_a     = vecs[i].wa;  wb_alu_a_rd  = vecs[i].wa_rd;
      wb_alu_b     = vecs[i].wb;  wb_alu_b_rd  = vecs[i].wb_rd;
      wb_branch    = vecs[i].wbr; wb_branch_rd = vecs[i].wbr_rd;
      wb_ldst      = vecs[i].wl;  wb_ldst_rd   = vecs[i].wl_rd;
      step(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ebr, 16'h0000, vecs[i].eld);
    end

    // Mul r5: visible three cycles, gone on the fourth.
    cur_a = op(EU_MUL, 4'd5); dispatch_a = 1'b1;
    step("mul_r5_c1", MUL_EN ? 16'h0 : 16'h0020, 16'h0, 16'h0, MUL_EN ? 16'h0020 : 16'h0, 16'h0);
    step("mul_r5_c2", MUL_EN ? 16'h0 : 16'h0020, 16'h0, 16'h0, MUL_EN ? 16'h0020 : 16'h0, 16'h0);
    step("mul_r5_c3", MUL_EN ? 16'h0 : 16'h0020, 16'h0, 16'h0, MUL_EN ? 16'h0020 : 16'h0, 16'h0);
    step("mul_r5_c4", MUL_EN ? 16'h0 : 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0);
    wb_alu_a = 1'b1; wb_alu_a_rd = 4'd5;
    step("mul_r5_drain", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Back-to-back mul r6: bit held until the younger entry exits.
    cur_a = op(EU_MUL, 4'd6); dispatch_a = 1'b1;
    step("mul_b2b_c1", MUL_EN ? 16'h0 : 16'h0040, 16'h0, 16'h0, MUL_EN ? 16'h0040 : 16'h0, 16'h0);
    cur_a = op(EU_MUL, 4'd6); dispatch_a = 1'b1;
    step("mul_b2b_c2", MUL_EN ? 16'h0 : 16'h0040, 16'h0, 16'h0, MUL_EN ? 16'h0040 : 16'h0, 16'h0);
    step("mul_b2b_c3", MUL_EN ? 16'h0 : 16'h0040, 16'h0, 16'h0, MUL_EN ? 16'h0040 : 16'h0, 16'h0);
    step("mul_b2b_c4", MUL_EN ? 16'h0 : 16'h0040, 16'h0, 16'h0, MUL_EN ? 16'h0040 : 16'h0, 16'h0);
    step("mul_b2b_c5", MUL_EN ? 16'h0 : 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0);
    wb_alu_a = 1'b1; wb_alu_a_rd = 4'd6;
    step("mul_b2b_drain", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset mid-flight with ldst r8 and mul r4 pending.
    cur_a = op(EU_LDST, 4'd8); dispatch_a = 1'b1;
    cur_b = op(EU_MUL, 4'd4);  dispatch_b = 1'b1;
    step("pre_reset", 16'h0, MUL_EN ? 16'h0 : 16'h0010, 16'h0, MUL_EN ? 16'h0010 : 16'h0, 16'h0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    #2;
    rst_n = 1'b1;

    // First edge after release accepts a dispatch; mul r4 runs its full latency.
    cur_a = op(EU_MUL, 4'd4); dispatch_a = 1'b1;
    step("post_rst_c1", MUL_EN ? 16'h0 : 16'h0010, 16'h0, 16'h0, MUL_EN ? 16'h0010 : 16'h0, 16'h0);
    step("post_rst_c2", MUL_EN ? 16'h0 : 16'h0010, 16'h0, 16'h0, MUL_EN ? 16'h0010 : 16'h0, 16'h0);
    step("post_rst_c3", MUL_EN ? 16'h0 : 16'h0010, 16'h0, 16'h0, MUL_EN ? 16'h0010 : 16'h0, 16'h0);
    step("post_rst_c4", MUL_EN ? 16'h0 : 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0);
    wb_alu_a = 1'b1; wb_alu_a_rd = 4'd4;
    step("post_rst_drain", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step("post_rst_quiet", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_dispatch_scoreboard.md
CORE_DISPATCH_SCOREBOARD -- requirements
Module: core_dispatch_scoreboard

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 3: cycles from mul dispatch to mul result writeback; legal range 1..8.
REQ-002 SHALL have port clk  input  1  the single core clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports cur_a, cur_b  input  insn_decode  the decoded instruction pair presented to dispatch this cycle.
REQ-005 SHALL have ports dispatch_a, dispatch_b  input  1  the dispatch decisions for cur_a and cur_b in this cycle.
REQ-006 SHALL have ports wb_alu_a, wb_alu_b, wb_branch, wb_ldst  input  1  the named EU writes its result this cycle.
REQ-007 SHALL have ports wb_alu_a_rd, wb_alu_b_rd, wb_branch_rd, wb_ldst_rd  input  reg_num  destination of that writeback.
REQ-008 SHALL have ports mask_alu_a, mask_alu_b, mask_branch, mask_mul, mask_ldst  output  hword  registers with a pending write per EU.
REQ-009 SHALL have ports mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb  output  hword  one-hot read-operand masks of cur_a/cur_b.
REQ-010 SHALL have port busy  output  1  high while any pending mask bit is set.

Function
REQ-011 SHALL set, on a clock edge, bit cur_X.data.rd in exactly one EU mask when dispatch_X=1, cur_X.ctrl.execute=1 and cur_X.data.writeback=1.
REQ-012 SHALL route that set by class: branch -> mask_branch, mul -> mask_mul, ldst -> mask_ldst, otherwise slot A -> mask_alu_a and slot B -> mask_alu_b.
REQ-013 SHALL clear bit wb_E_rd of mask_E on the edge where wb_E=1, for E in alu_a, alu_b, branch, ldst.
REQ-014 SHALL clear mul bits internally via a MUL_LATENCY-deep shift pipe of (valid, rd): entry enters on mul dispatch, bit clears on the edge where it exits.
REQ-015 SHALL give set priority over clear when the same bit of the same EU mask is set and cleared in one cycle.
REQ-016 SHALL ignore a clear of a bit not currently set; the mask remains unchanged.
REQ-017 SHALL treat simultaneous sets from slots A and B to different EUs independently; same rd in two EU masks is legal.
REQ-018 SHALL drive mask_X_ra = (1 << cur_X.data.ra) when cur_X.data.uses_ra and cur_X.ctrl.execute, else 0; likewise rb.
REQ-019 SHALL make REQ-018 outputs purely combinational, zero latency; EU masks SHALL be registered outputs.
REQ-020 SHALL cause a bit set at edge N to be visible on its mask output in cycle N+1.
REQ-021 SHALL make a mul dispatched at edge N clear at edge N+MUL_LATENCY.
REQ-022 SHALL make a back-to-back mul to the same rd keep the bit set until the younger entry exits.
REQ-023 SHALL ignore dispatch_b when dispatch_a=0 (in-order pair; B never issues alone).

Reset
REQ-024 SHALL, while rst_n=0, force all EU masks to 0, empty the mul pipe and drive busy=0, regardless of clk.
REQ-025 SHALL discard in-flight mul entries on reset mid-operation, with no clear pulses after release.
REQ-026 SHALL accept dispatch on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with CORE_MUL_EN defined, implement the mul pipe and mask_mul per REQ-014/021/022.
REQ-028 SHALL, without CORE_MUL_EN, remove the mul pipe and tie mask_mul to 0; mul-class instructions SHALL then be tracked as ALU per slot.

Structure
REQ-029 SHALL take hword, reg_num and insn_decode from the shared core uarch package; add no new shared typedefs.
REQ-030 SHALL place the mul latency pipe in sub-module core_dispatch_mul_track (params MUL_LATENCY; outputs exit valid and rd).

Verification
REQ-031 SHALL verify: A=add r3 dispatched, wb_alu_a rd=3 two cycles later -> mask_alu_a=0x0008 for two cycles, then 0x0000.
REQ-032 SHALL verify: MUL_LATENCY=3, mul r5 dispatched at edge 0 -> mask_mul=0x0020 in cycles 1..3, 0 in cycle 4.
REQ-033 SHALL verify: set and wb_alu_b of r7 in the same cycle -> mask_alu_b bit 7 stays 1.
REQ-034 SHALL verify: dispatch_a=0, dispatch_b=1, B writes r2 -> all masks remain 0.
REQ-035 SHALL verify: rst_n low mid-flight with mask_ldst=0x0100 and mul pending -> all masks 0 immediately, busy=0, no later clears.
REQ-036 SHALL verify: cur_a uses ra=4, rb=9 -> mask_a_ra=0x0010, mask_a_rb=0x0200 in the same cycle.
